// File: rtl/if_id_buffer.sv
// Two-entry skid buffer between fetch and decode.
// Carries {pc, instr} pairs with a valid/ready handshake and drops wrong-path entries on flush.
module if_id_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_f,
  input  logic [WIDTH-1:0] instr_f,
  input  logic             valid_f,
  output logic             ready_f,
  input  logic             flush,
  output logic [WIDTH-1:0] pc_d,
  output logic [WIDTH-1:0] instr_d,
  output logic [WIDTH-1:0] pc_plus4_d,
  output logic             valid_d,
  input  logic             ready_d,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic             head;
  logic             tail;
  logic [WIDTH-1:0] pc_mem    [2];
  logic [WIDTH-1:0] instr_mem [2];

  logic push;
  logic pop;

  // ready_f depends only on registered state, never on ready_d
  assign ready_f    = (state != FULL);
  assign valid_d    = (state != EMPTY) && !flush;
  assign push       = valid_f && ready_f && !flush;
  assign pop        = valid_d && ready_d;

  assign pc_d       = pc_mem[head];
  assign instr_d    = instr_mem[head];
  assign pc_plus4_d = pc_d + WIDTH'(4);
  assign occupancy  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= EMPTY;
      head         <= 1'b0;
      tail         <= 1'b0;
      pc_mem[0]    <= '0;
      pc_mem[1]    <= '0;
      instr_mem[0] <= '0;
      instr_mem[1] <= '0;
    end else if (flush) begin
      state <= EMPTY;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else begin
      if (push) begin
        pc_mem[tail]    <= pc_f;
        instr_mem[tail] <= instr_f;
        tail            <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      case (state)
        EMPTY:   if (push) state <= ONE;
        ONE:     if (push && !pop) state <= FULL;
                 else if (!push && pop) state <= EMPTY;
        FULL:    if (pop) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
Two-entry skid buffer sitting between the fetch stage (if_stage plus instruction_mem) and the decode stage of the RSA-decryption ASIP pipeline. It captures each fetched {pc, instr} pair and presents it to decode with a valid/ready handshake. It back-pressures fetch when full and discards wrong-path instructions when a jump is taken (pc_selector=1).

Parameters:
WIDTH, 32, bit width of pc, instr and all datapath fields
(depth is fixed at 2 entries; not parameterised)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
pc_f  input  WIDTH  pc of the fetched instruction (from if_stage)
instr_f  input  WIDTH  instruction word (from instruction_mem)
valid_f  input  1  fetch presents a valid {pc_f, instr_f}
ready_f  output  1  buffer accepts an entry this cycle; fetch holds pc when 0
flush  input  1  taken jump/branch; drop all buffered and incoming entries
pc_d  output  WIDTH  pc of head entry
instr_d  output  WIDTH  instruction of head entry
pc_plus4_d  output  WIDTH  pc_d + 4
valid_d  output  1  head entry valid for decode
ready_d  input  1  decode consumes head this cycle
occupancy  output  2  entries held (0..2), for debug/perf counters

Behaviour:
- Storage: two entries {pc, instr}, head/tail pointers (1 bit each) plus a 2-bit count; states EMPTY (0), ONE (1), FULL (2).
- All state changes occur on the rising edge of clk. reset takes effect on the edge only: count=0, pointers=0, entry storage=0.
- Outputs after reset: valid_d=0, pc_d=0, instr_d=0, pc_plus4_d=4, ready_f=1, occupancy=0.
- ready_f = (count != 2). It is driven from registered state only and has no combinational path from ready_d.
- valid_d = (count != 0) && !flush. pc_d/instr_d always show the head entry; when count=0 they show stale storage and carry no meaning.
- push = valid_f && ready_f && !flush. pop = valid_d && ready_d (pop is therefore impossible during flush).
- Transitions:
  - EMPTY + push -> ONE.
  - ONE + push, no pop -> FULL.
  - ONE + push + pop -> ONE; the new entry becomes head on the next cycle.
  - ONE + pop -> EMPTY.
  - FULL + pop -> ONE. push cannot occur in FULL.
- Zero-bubble streaming: with ready_d held at 1 and valid_f held at 1, one entry moves per cycle with 1-cycle latency from fetch to decode.
- flush: highest priority below reset. On the next edge count=0 and pointers=0. The same-cycle fetch entry is discarded. Entries arriving from the cycle after flush deasserts are accepted normally (the jump target).
- Ordering: strict FIFO; entries never reorder or duplicate.
- pc_plus4_d = pc_d + 4, truncated to WIDTH (32'hFFFFFFFC -> 32'h00000000).
- Reset during any state, including simultaneous flush/push/pop: reset wins, and the buffer is EMPTY on the next cycle.
- valid_f=1 while ready_f=0: no capture. Fetch must hold pc_f/instr_f stable; the buffer does not latch them.

Test Plan:
- Reset, then stream: pc_f=0,4,8,C with instr_f=A,B,C,D, valid_f=1, ready_d=1 -> pc_d/instr_d follow 1 cycle later; valid_d=1 each cycle; occupancy stays 1; ready_f never 0.
- Back-pressure: ready_d=0, push pc 0,4,8 on consecutive cycles -> occupancy 1,2,2; ready_f=0 after the 2nd push; pc 8 is not captured. Then ready_d=1 -> pc_d=0 then 4, ready_f=1 again.
- Simultaneous push+pop in ONE: head pc=10, push pc=14 with ready_d=1 -> next cycle pc_d=14, occupancy=1.
- Flush while FULL: entries pc 20,24 held, flush=1 with valid_f=1 pc_f=28 -> valid_d=0 during the flush cycle. Next cycle occupancy=0. Then push jmp target pc=5C -> pc_d=5C, pc_plus4_d=60.
- Wrap: push pc=FFFFFFFC -> pc_plus4_d=00000000.
- Reset mid-operation: FULL with ready_d=0, assert reset for 1 cycle -> valid_d=0, occupancy=0, ready_f=1, pc_d=0 on the following cycle.
